// File: rtl/rr_arbiter8_if.sv
// rtl/rr_arbiter8_if.sv - request/grant bundle between requesters and rr_arbiter8
interface rr_arbiter8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       preempt;

  modport master (
    output req,
    output done,
    input  gnt,
    input  sel,
    input  busy,
    input  preempt
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output sel,
    output busy,
    output preempt
  );
endinterface

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-way round-robin arbiter with release handshake and hold-time preemption
module rr_arbiter8 #(
  parameter int MaxHold = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter8_if.slave  bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [7:0] HoldLast = (MaxHold == 0) ? 8'd0 : 8'(MaxHold - 1);

  logic [0:0] state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] hold_q, hold_d;
  logic       pre_q, pre_d;

  logic [7:0] others;
  logic       owner_req;
  logic       limit_hit;
  logic       release_now;
  logic [3:0] win_idle;
  logic [3:0] win_other;

  // Returns {found, index} of the first set bit scanning p+1 .. p+8 (mod 8).
  function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] k;
    res = 4'd0;
    for (int i = 1; i <= 8; i++) begin
      k = p + 3'(i);
      if (!res[3] && r[k]) res = {1'b1, k};
    end
    return res;
  endfunction

  always_comb begin
    others      = bus.req & ~gnt_q;
    owner_req   = bus.req[sel_q];
    limit_hit   = (MaxHold != 0) && (hold_q == HoldLast) && (others != 8'd0);
    release_now = bus.done || !owner_req || limit_hit;
    win_idle    = pick(bus.req, ptr_q);
    win_other   = pick(others, sel_q);

    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    pre_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_idle[3]) begin
          state_d = GRANT;
          gnt_d   = 8'b1 << win_idle[2:0];
          sel_d   = win_idle[2:0];
          hold_d  = 8'd0;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_d = sel_q;
          if (win_other[3]) begin
            gnt_d  = 8'b1 << win_other[2:0];
            sel_d  = win_other[2:0];
            hold_d = 8'd0;
            // Only a pure hold-limit revocation is flagged as preemption.
            pre_d  = limit_hit && !bus.done && owner_req;
          end else if (owner_req) begin
            hold_d = 8'd0;
          end else begin
            state_d = IDLE;
            gnt_d   = 8'd0;
          end
        end else if (hold_q != HoldLast) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 8'd0;
      sel_q   <= 3'd0;
      ptr_q   <= 3'd7;
      hold_q  <= 8'd0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      pre_q   <= pre_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.sel     = sel_q;
  assign bus.busy    = |gnt_q;
  assign bus.preempt = pre_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - directed self-checking bench for rr_arbiter8
module tb_rr_arbiter8;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;
  int   bad;

  rr_arbiter8_if ifa ();
  rr_arbiter8_if ifb ();
  rr_arbiter8_if ifc ();

  rr_arbiter8 #(.MaxHold(16)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  rr_arbiter8 #(.MaxHold(4))  u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  rr_arbiter8 #(.MaxHold(2))  u_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    ifa.req = 8'h00; ifa.done = 1'b0;
    ifb.req = 8'h00; ifb.done = 1'b0;
    ifc.req = 8'h00; ifc.done = 1'b0;
    #2;
    check("rst_gnt", ifa.gnt, 8'h00);
    check("rst_sel", 8'(ifa.sel), 8'h00);
    check("rst_busy", 8'(ifa.busy), 8'h00);
    check("rst_pre", 8'(ifa.preempt), 8'h00);
    tick(2);
    rst_n = 1'b1;

    // single requester, then release with done
    ifa.req = 8'h01;
    tick();
    check("t1_gnt", ifa.gnt, 8'h01);
    check("t1_sel", 8'(ifa.sel), 8'h00);
    check("t1_busy", 8'(ifa.busy), 8'h01);
    ifa.req = 8'h00; ifa.done = 1'b1;
    tick();
    ifa.done = 1'b0;
    check("t1_idle_gnt", ifa.gnt, 8'h00);
    check("t1_idle_busy", 8'(ifa.busy), 8'h00);
    check("t1_idle_sel", 8'(ifa.sel), 8'h00);

    // full rotation with done every cycle
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ifa.req = 8'hFF; ifa.done = 1'b1;
    tick();
    check("t2_first", ifa.gnt, 8'h01);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("t2_gnt", ifa.gnt, 8'h01 << (i % 8));
      check("t2_sel", 8'(ifa.sel), 8'(i % 8));
      check("t2_pre", 8'(ifa.preempt), 8'h00);
    end
    ifa.req = 8'h00;
    tick();
    ifa.done = 1'b0;
    check("t2_idle", 8'(ifa.busy), 8'h00);

    // hold-limit preemption, MaxHold=4
    ifb.req = 8'h05;
    tick();
    check("t3_own0", ifb.gnt, 8'h01);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_hold0", ifb.gnt, 8'h01);
    end
    tick();
    check("t3_gnt2", ifb.gnt, 8'h04);
    check("t3_sel2", 8'(ifb.sel), 8'h02);
    check("t3_pre1", 8'(ifb.preempt), 8'h01);
    tick();
    check("t3_pre_pulse", 8'(ifb.preempt), 8'h00);
    tick(2);
    check("t3_hold2", ifb.gnt, 8'h04);
    tick();
    check("t3_back0", ifb.gnt, 8'h01);
    check("t3_back_pre", 8'(ifb.preempt), 8'h01);
    ifb.req = 8'h00;
    tick();

    // no preemption without contention, then contention arrives
    ifb.req = 8'h08;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ifb.gnt !== 8'h08 || ifb.preempt !== 1'b0) bad++;
    end
    check("t4_solo_bad", 8'(bad), 8'h00);
    ifb.req = 8'h18;
    tick();
    check("t4_gnt4", ifb.gnt, 8'h10);
    check("t4_pre", 8'(ifb.preempt), 8'h01);
    ifb.req = 8'h00;
    tick();

    // withdraw by owner 5, then asynchronous reset mid-grant
    ifa.req = 8'h20;
    tick();
    check("t5_gnt5", ifa.gnt, 8'h20);
    check("t5_sel5", 8'(ifa.sel), 8'h05);
    ifa.req = 8'h02;
    tick();
    check("t5_gnt1", ifa.gnt, 8'h02);
    check("t5_sel1", 8'(ifa.sel), 8'h01);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_arst_gnt", ifa.gnt, 8'h00);
    check("t5_arst_busy", 8'(ifa.busy), 8'h00);
    check("t5_arst_sel", 8'(ifa.sel), 8'h00);
    ifa.req = 8'h00;
    tick();
    rst_n = 1'b1;

    // done coincident with hold limit, MaxHold=2
    ifc.req = 8'h03;
    tick();
    check("t6_own0", ifc.gnt, 8'h01);
    tick();
    check("t6_hold0", ifc.gnt, 8'h01);
    ifc.done = 1'b1;
    tick();
    ifc.done = 1'b0;
    check("t6_gnt1", ifc.gnt, 8'h02);
    check("t6_sel1", 8'(ifc.sel), 8'h01);
    check("t6_pre0", 8'(ifc.preempt), 8'h00);
    tick(2);
    check("t6_lim_gnt", ifc.gnt, 8'h01);
    check("t6_lim_pre", 8'(ifc.preempt), 8'h01);
    ifc.req = 8'h00;
    tick();

    // lone owner regranted on done
    ifa.req = 8'h04;
    tick();
    check("t7_gnt", ifa.gnt, 8'h04);
    ifa.done = 1'b1;
    tick();
    ifa.done = 1'b0;
    check("t7_regnt", ifa.gnt, 8'h04);
    check("t7_busy", 8'(ifa.busy), 8'h01);
    check("t7_pre", 8'(ifa.preempt), 8'h00);
    ifa.req = 8'h00;
    tick();
    check("t7_idle", ifa.gnt, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one 8-input resource between 8 requesters (register-file write port, memory bus, or similar).
- Its encoded grant `sel` drives the select of the team's 8:1 data multiplexer directly.
- Provides back-to-back re-arbitration, a release handshake, and an optional hold-time limit that preempts an owner under contention.

Parameters:
- MaxHold, 16: max consecutive grant cycles for one owner while another requester is pending. Range 0..255; 0 = unlimited.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  8  request vector, bit i = requester i; level-sensitive, held until served
- done  input  1  current owner finishes its transfer this cycle; ignored when not busy
- gnt  output  8  one-hot grant, registered; all zero when idle
- sel  output  3  binary index of current or last owner, registered; feeds 8:1 mux select
- busy  output  1  1 while a grant is active (gnt != 0)
- preempt  output  1  one-cycle pulse, registered; high in the first cycle of a grant that followed a hold-limit revocation

Behaviour:
- Reset (rst_n=0, asynchronous, immediate, any state): gnt=0, sel=0, busy=0, preempt=0, hold counter=0, round-robin pointer=7 so requester 0 has top priority first. State goes to IDLE.
- State IDLE:
  - gnt=0, sel holds last owner.
  - If req!=0 at an edge: go to GRANT; gnt/sel/busy show the winner from that edge. Latency is 1 cycle from sampled req to gnt.
- Winner selection: first set bit of req scanning ptr+1, ptr+2, … mod 8 (wrap 7->0). ptr = last owner.
- State GRANT, release conditions evaluated at each edge:
  - (a) done=1;
  - (b) req[owner]=0 (requester withdrew);
  - (c) MaxHold!=0 and hold counter == MaxHold-1 and (req & ~gnt)!=0.
- On release:
  - ptr := owner.
  - Re-arbitrate in the same edge with owner excluded when any other request is pending.
  - If only the owner still requests and release is by done, owner is regranted, counter reset.
  - If no eligible request, go to IDLE (gnt=0 next cycle).
  - No dead cycle between back-to-back grants to different owners.
- Hold counter:
  - Cleared on every new grant (including regrant); increments each GRANT cycle without release.
  - Saturates at MaxHold-1 while no other request is pending, so no preemption without contention.
- preempt:
  - Set to 1 for exactly the first cycle of the grant that follows a release caused only by (c); 0 otherwise.
  - If done=1 or req[owner]=0 coincides with (c), it is a normal release and preempt=0.
- Invariants: gnt has popcount ≤1 every cycle; busy == |gnt; sel == encode(gnt) whenever busy.
- Changes on req bits other than the owner's never disturb an active grant, except via (c).

Test Plan:
- Reset then req=8'b0000_0001 -> 1 cycle later gnt=8'h01, sel=0, busy=1; done pulse with req=0 -> next cycle gnt=0, busy=0, sel stays 0.
- req=8'hFF held, done pulsed every cycle -> gnt sequence 01,02,04,…,80,01 (wrap), sel 0..7,0, no idle gap, preempt=0 throughout.
- MaxHold=4, req=8'h05, done never asserted -> owner 0 holds exactly 4 cycles; gnt=8'h04, sel=2, preempt=1 for one cycle; owner 2 preempted after 4 cycles back to owner 0.
- MaxHold=4, req=8'h08 alone for 20 cycles -> gnt=8'h08 for all 20 cycles, preempt never asserted; then req=8'h18 -> owner 3 released within 4 cycles, gnt=8'h10.
- Owner 5 granted, req[5] dropped with req[1]=1 -> next cycle gnt=8'h02, sel=1; rst_n pulsed low mid-grant -> gnt=0, busy=0, sel=0 immediately, before the next clk edge.
- Coincident done and hold limit with req=8'h03, MaxHold=2 -> switch to owner 1 with preempt=0.
